// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: owns the single memory port and shares it between the CPU
// and the OAM DMA engine. A CPU write to 0xFF46 copies DMA_LEN bytes from
// {page,8'h00} to 0xFE00; during the copy the CPU only reaches 0xFF46.
// Optional feature macro: DMA_DONE_PULSE_EN adds a one-cycle dma_done output.
module oam_dma_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int DMA_LEN     = 160,
  parameter int START_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_wr_en,
  input  logic                  cpu_rd_en,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef DMA_DONE_PULSE_EN
  output logic                  dma_done,
`endif
  output logic                  dma_active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_READ,
    S_WRITE
  } state_t;

  localparam int DCNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = ADDR_WIDTH'(16'hFF46);
  localparam logic [7:0]            LAST_IDX     = 8'(DMA_LEN - 1);
  localparam logic [DCNT_W-1:0]     DCNT_RELOAD  = DCNT_W'(START_DELAY - 1);

  state_t            state;
  logic [7:0]        idx;
  logic [7:0]        src_page;
  logic [7:0]        byte_latch;
  logic [DCNT_W-1:0] dcnt;
  logic [7:0]        eff_page;
  logic              reg_hit;
  logic              reg_wr;
  logic              cpu_rd_only;

  assign reg_hit     = (cpu_addr == DMA_REG_ADDR);
  assign reg_wr      = cpu_wr_en && reg_hit;
  // Write wins when both strobes are raised, so a read is only a read alone.
  assign cpu_rd_only = cpu_rd_en && !cpu_wr_en;

  // Pages 0xE0..0xFF mirror work RAM at 0xC0..0xDF (echo RAM fold).
  assign eff_page = (src_page >= 8'hE0) ? (src_page - 8'h20) : src_page;

  // Transfer sequencer: trigger/restart, start delay, then read/write byte pairs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 8'h00;
      src_page   <= 8'h00;
      byte_latch <= 8'h00;
      dcnt       <= '0;
      dma_active <= 1'b0;
`ifdef DMA_DONE_PULSE_EN
      dma_done   <= 1'b0;
`endif
    end else begin
`ifdef DMA_DONE_PULSE_EN
      dma_done <= 1'b0;
`endif
      if (reg_wr) begin
        // A register write always (re)starts; a byte being written this cycle
        // still reaches memory because the port mux follows the current state.
        src_page   <= cpu_wdata[7:0];
        idx        <= 8'h00;
        dcnt       <= DCNT_RELOAD;
        state      <= S_DELAY;
        dma_active <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_IDLE;
          end
          S_DELAY: begin
            if (dcnt == '0) begin
              state      <= S_READ;
              dma_active <= 1'b1;
            end else begin
              dcnt <= dcnt - 1'b1;
            end
          end
          S_READ: begin
            byte_latch <= mem_rdata[7:0];
            state      <= S_WRITE;
          end
          S_WRITE: begin
            if (idx == LAST_IDX) begin
              idx        <= 8'h00;
              state      <= S_IDLE;
              dma_active <= 1'b0;
`ifdef DMA_DONE_PULSE_EN
              dma_done   <= 1'b1;
`endif
            end else begin
              idx   <= idx + 8'h01;
              state <= S_READ;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Port mux: DMA owns the port in READ/WRITE, CPU passes through otherwise.
  // HRAM needs no separate path: while the DMA holds the port it is treated
  // like any other locked-out address (reads 0xFF, writes dropped).
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    cpu_rdata = '1;
    if (rst_n) begin
      if (state == S_READ) begin
        mem_addr  = ADDR_WIDTH'({eff_page, idx});
        mem_rd_en = 1'b1;
      end else if (state == S_WRITE) begin
        mem_addr  = ADDR_WIDTH'({8'hFE, idx});
        mem_wdata = DATA_WIDTH'(byte_latch);
        mem_wr_en = 1'b1;
      end else if (!reg_hit) begin
        if (cpu_wr_en) begin
          mem_wr_en = 1'b1;
        end else if (cpu_rd_en) begin
          mem_rd_en = 1'b1;
          cpu_rdata = mem_rdata;
        end
      end
      if (cpu_rd_only && reg_hit) begin
        cpu_rdata = DATA_WIDTH'(src_page);
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: directed bench with a cycle-level behavioural model of
// the DMA schedule (phase counted from the trigger edge) and an asynchronous
// memory model; one negedge process compares every cycle.
module tb_oam_dma_arbiter;

  localparam int SD = 1;
  localparam int L  = 160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr_en;
  logic        cpu_rd_en;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;
  logic        dma_active;
`ifdef DMA_DONE_PULSE_EN
  logic        dma_done;
`endif

  int total = 0;
  int bad   = 0;

  oam_dma_arbiter #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .DMA_LEN    (L),
    .START_DELAY(SD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wr_en (cpu_wr_en),
    .cpu_rd_en (cpu_rd_en),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
`ifdef DMA_DONE_PULSE_EN
    .dma_done  (dma_done),
`endif
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // Asynchronous memory with a one-time preload on the first edge.
  logic [7:0] mem [0:65535];
  bit         mem_init_done = 1'b0;

  function automatic logic [7:0] init_val(input int a);
    logic [15:0] a16;
    a16 = 16'(a);
    if (a16 >= 16'hC000 && a16 <= 16'hC09F) return a16[7:0] ^ 8'h5A;
    if (a16 >= 16'hC100 && a16 <= 16'hC19F) return a16[7:0] ^ 8'h3C;
    if (a16 >= 16'hD000 && a16 <= 16'hD09F) return a16[7:0] ^ 8'hA5;
    if (a16 == 16'h8000) return 8'h12;
    return 8'h00;
  endfunction

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_val(a);
      mem_init_done <= 1'b1;
    end else if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transfer is "phase cycles since the trigger edge".
  // Phases [SD, SD+2L) own the port; even offsets read, odd offsets write.
  bit         m_run   = 1'b0;
  int         m_phase = 0;
  logic [7:0] m_page  = 8'h00;
  bit         m_done  = 1'b0;
  logic [7:0] m_latch = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 1'b0; m_phase = 0; m_page = 8'h00; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (cpu_wr_en && cpu_addr == 16'hFF46) begin
        m_page = cpu_wdata; m_run = 1'b1; m_phase = 0;
      end else if (m_run) begin
        m_phase++;
        if (m_phase == SD + 2 * L) begin
          m_run = 1'b0; m_done = 1'b1;
        end
      end
    end
  end

  bit          c_act;
  int          c_k;
  logic [7:0]  c_idx;
  logic [7:0]  c_eff;
  logic [7:0]  c_rdata;
  bit          c_rd_only;
  bit          c_hit;

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    c_act     = m_run && m_phase >= SD && m_phase < SD + 2 * L;
    c_rd_only = cpu_rd_en && !cpu_wr_en;
    c_hit     = (cpu_addr == 16'hFF46);
    chk("dma_active", dma_active, c_act);
`ifdef DMA_DONE_PULSE_EN
    chk("dma_done", dma_done, m_done);
`endif
    if (!rst_n) begin
      chk("rst_mem_wr_en", mem_wr_en, 1'b0);
      chk("rst_mem_rd_en", mem_rd_en, 1'b0);
      chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    end else begin
      c_rdata = 8'hFF;
      if (c_act) begin
        c_k   = m_phase - SD;
        c_idx = 8'(c_k / 2);
        c_eff = (m_page >= 8'hE0) ? m_page - 8'h20 : m_page;
        if (c_k % 2 == 0) begin
          chk("dma_rd_en", mem_rd_en, 1'b1);
          chk("dma_rd_wr_en", mem_wr_en, 1'b0);
          chk("dma_rd_addr", mem_addr, {c_eff, c_idx});
          m_latch = mem[{c_eff, c_idx}];
        end else begin
          chk("dma_wr_en", mem_wr_en, 1'b1);
          chk("dma_wr_rd_en", mem_rd_en, 1'b0);
          chk("dma_wr_addr", mem_addr, {8'hFE, c_idx});
          chk("dma_wr_data", mem_wdata, m_latch);
        end
        if (c_rd_only && c_hit) c_rdata = m_page;
      end else begin
        if (cpu_wr_en && !c_hit) begin
          chk("pt_wr_en", mem_wr_en, 1'b1);
          chk("pt_wr_addr", mem_addr, cpu_addr);
          chk("pt_wr_data", mem_wdata, cpu_wdata);
          chk("pt_wr_rd_en", mem_rd_en, 1'b0);
        end else if (c_rd_only && !c_hit) begin
          chk("pt_rd_en", mem_rd_en, 1'b1);
          chk("pt_rd_addr", mem_addr, cpu_addr);
          chk("pt_rd_wr_en", mem_wr_en, 1'b0);
          c_rdata = mem[cpu_addr];
        end else begin
          chk("idle_wr_en", mem_wr_en, 1'b0);
          chk("idle_rd_en", mem_rd_en, 1'b0);
          if (c_rd_only) c_rdata = m_page;
        end
      end
      chk("cpu_rdata", cpu_rdata, c_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_wr_en = 1'b1;
    tick();
    cpu_wr_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    cpu_addr = a; cpu_rd_en = 1'b1;
    @(negedge clk);
    d = cpu_rdata;
    tick();
    cpu_rd_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dma_active && n < 1000) begin
      tick();
      n++;
    end
    chk("idle_timeout", dma_active, 1'b0);
    tick();
  endtask

  task automatic count_active(input string name);
    int n;
    n = 0;
    while (dma_active && n < 1000) begin
      tick();
      n++;
    end
    chk(name, n, 2 * L);
  endtask

  logic [7:0] rd;

  initial begin
    // 1 Reset with a CPU read pending.
    rst_n = 1'b0; cpu_addr = 16'hC000; cpu_wdata = 8'h00;
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b1;
    @(negedge clk);
    chk("t1_mem_rd_en", mem_rd_en, 1'b0);
    chk("t1_cpu_rdata", cpu_rdata, 8'hFF);
    chk("t1_dma_active", dma_active, 1'b0);
    tick();
    rst_n = 1'b1; cpu_rd_en = 1'b0;
    tick();
    cpu_read(16'hFF46, rd);
    chk("t1_ff46_reset", rd, 8'h00);

    // Idle pass-through and simultaneous strobes.
    cpu_read(16'hC005, rd);
    chk("pt_read_c005", rd, 8'h5F);
    cpu_addr = 16'h8001; cpu_wdata = 8'h44; cpu_wr_en = 1'b1; cpu_rd_en = 1'b1;
    @(negedge clk);
    rd = cpu_rdata;
    tick();
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b0;
    chk("rw_both_rdata", rd, 8'hFF);
    chk("rw_both_mem", mem[16'h8001], 8'h44);

    // 2 Basic copy from page C0.
    cpu_write(16'hFF46, 8'hC0);
    chk("t2_active_delay", dma_active, 1'b0);
    tick();
    chk("t2_active_rise", dma_active, 1'b1);
    count_active("t2_active_len");
    chk("t2_fe00", mem[16'hFE00], 8'h5A);
    chk("t2_fe50", mem[16'hFE50], 8'h0A);
    chk("t2_fe9f", mem[16'hFE9F], 8'hC5);
    chk("t2_fea0", mem[16'hFEA0], 8'h00);
    tick();

    // 3 Lockout during a copy.
    cpu_write(16'hFF46, 8'hC0);
    repeat (10) tick();
    cpu_read(16'h8000, rd);
    chk("t3_read_8000", rd, 8'hFF);
    cpu_write(16'hC123, 8'h77);
    cpu_read(16'hFF80, rd);
    chk("t3_read_hram", rd, 8'hFF);
    cpu_read(16'hFF46, rd);
    chk("t3_read_ff46", rd, 8'hC0);
    wait_idle();
    chk("t3_c123_kept", mem[16'hC123], 8'h1F);

    // 5 Echo fold: page E1 reads from C1.
    cpu_write(16'hFF46, 8'hE1);
    tick();
    chk("t5_first_addr", mem_addr, 16'hC100);
    wait_idle();
    chk("t5_fe00", mem[16'hFE00], 8'h3C);
    chk("t5_fe9f", mem[16'hFE9F], 8'hA3);
    cpu_read(16'hFF46, rd);
    chk("t5_ff46", rd, 8'hE1);

    // 4 Restart at idx 50 (write cycle of byte 50).
    cpu_write(16'hFF46, 8'hC0);
    repeat (2 * 50 + 2) tick();
    cpu_write(16'hFF46, 8'hD0);
    chk("t4_byte50_commit", mem[16'hFE32], 8'h68);
    chk("t4_byte51_old", mem[16'hFE33], 8'h0F);
    tick();
    count_active("t4_restart_len");
    chk("t4_fe00", mem[16'hFE00], 8'hA5);
    chk("t4_fe32", mem[16'hFE32], 8'h97);
    chk("t4_fe9f", mem[16'hFE9F], 8'h3A);
    tick();

    // 6 Reset during the read of byte 10.
    cpu_write(16'hFF46, 8'hC0);
    repeat (2 * 10 + 1) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t6_fe09_done", mem[16'hFE09], 8'h53);
    chk("t6_fe0a_kept", mem[16'hFE0A], 8'hAF);
    chk("t6_active_off", dma_active, 1'b0);
    cpu_read(16'hFF46, rd);
    chk("t6_ff46_reset", rd, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
